lut_read_arbiter: RTL and testbench
===================================

// Module: lut_read_arbiter
// PURPOSE
// - Shares the single 32x8 read-only lookup table between NUM_REQ requesters
//   (e.g. decode and ALU). Sits between the requesters and the LUT.
// - Arbitrates round-robin, drives the LUT address, and registers the result.
// - Returns data tagged to the winning requester.
// PARAMETERS
// NUM_REQ        2    number of requesters (2..4)
// ADDR_W         5    LUT address width
// DATA_W         8    LUT data width
// VALID_ENTRIES  15   addresses 0..VALID_ENTRIES-1 are populated; others are out-of-range
// CNT_W          16   statistics counter width (LUT_ARB_STATS_EN only)
// PORTS
// clk          in   1               clock; all state updates on rising edge
// rst_n        in   1               asynchronous, active-low reset
// req          in   NUM_REQ         per-requester lookup request, level
// req_addr     in   NUM_REQ*ADDR_W  flattened addresses; slice i = [i*ADDR_W +: ADDR_W]
// gnt          out  NUM_REQ         one-hot grant pulse, registered
// rvalid       out  NUM_REQ         one-hot response-valid pulse, registered
// rdata        out  DATA_W          response data, qualified by |rvalid
// rerr         out  1               response was out-of-range, qualified by |rvalid
// lut_addr     out  ADDR_W          address to LUT
// lut_data     in   DATA_W          combinational LUT data for lut_addr
// lookup_cnt   out  CNT_W           completed lookups (LUT_ARB_STATS_EN only)
// err_cnt      out  CNT_W           out-of-range lookups (LUT_ARB_STATS_EN only)
// BEHAVIOUR
// - Reset values:
//   - state=IDLE; gnt=0; rvalid=0; rdata=0; rerr=0; lut_addr=0; counters=0.
//   - RR pointer last=NUM_REQ-1, so req[0] wins first.
// - FSM, two states:
//   - IDLE:
//     - Any req set: winner = first set bit scanning last+1, last+2, ... (mod NUM_REQ).
//     - Latch addr_q=req_addr[winner] and id_q=winner; set gnt[winner]=1 for the next cycle.
//     - last<=winner; go to LOOK.
//     - No req: stay in IDLE; gnt=0.
//   - LOOK:
//     - lut_addr=addr_q.
//     - Capture rdata<=(addr_q<VALID_ENTRIES)?lut_data:0 and rerr<=(addr_q>=VALID_ENTRIES).
//     - rvalid[id_q]<=1 for exactly the next cycle; go to IDLE.
//     - Requests are not sampled in LOOK.
// - Timing:
//   - req sampled at edge E0 -> gnt high in cycle after E0 -> rvalid/rdata high one cycle later.
//   - Latency 2 cycles; throughput 1 lookup per 2 cycles.
// - Requester protocol:
//   - Hold req and req_addr stable until gnt is seen.
//   - Drop req in the gnt cycle unless another lookup is wanted; it is then re-arbitrated.
//   - Changing req_addr before gnt is a protocol violation; the address latched at the IDLE edge is used.
// - rdata/rerr hold their last value while rvalid=0; lut_addr holds addr_q after LOOK.
// - Simultaneous requests resolve strictly by the RR pointer.
//   - All NUM_REQ requesters continuously requesting are served in order 0,1,..,NUM_REQ-1,0,...
// - Out-of-range address (>=VALID_ENTRIES, e.g. 20) is not an error stall:
//   - Completes normally with rdata=0, rerr=1.
// - Reset asserted mid-operation (any state):
//   - Immediately clears gnt/rvalid; the in-flight lookup is discarded, no response.
//   - The RR pointer returns to NUM_REQ-1.
// CONFIGURATION
// - LUT_ARB_STATS_EN defined:
//   - lookup_cnt increments on every rvalid pulse.
//   - err_cnt increments on every rvalid pulse with rerr=1.
//   - Both saturate at all-ones and do not wrap; both reset to 0.
// - LUT_ARB_STATS_EN undefined:
//   - lookup_cnt and err_cnt ports and counter logic are absent; all other behaviour is identical.
// TESTING (LUT contents 60+i for i=0..14)
// - Reset, then req=01, addr0=3 -> gnt=01 at +1 cycle; rvalid=01, rdata=63, rerr=0 at +2; idle after.
// - Simultaneous req=11, addr0=0, addr1=14, each dropped on its own gnt:
//   - req0 served first: rdata=60, rvalid=01.
//   - req1 served next: gnt=10 two cycles later, rdata=74, rvalid=10.
// - req=11 held continuously for 4 lookups -> grant order 01,10,01,10; gnt pulses 2 cycles apart; no dropped or duplicate rvalid.
// - req=10, addr1=20 -> rvalid=10, rdata=0, rerr=1; then addr1=14 -> rdata=74, rerr=0.
// - rst_n pulsed low during LOOK -> gnt=0 and rvalid=0 immediately; no response after release.
//   - Next req=11 -> req0 granted first.
// - LUT_ARB_STATS_EN: 3 lookups, one to addr 31 -> lookup_cnt=3, err_cnt=1.
//   - Force lookup_cnt to all-ones, do one more lookup -> stays all-ones.

Source files
------------

// File: rtl/lut_read_arbiter.sv
// Round-robin read arbiter sharing one combinational lookup table between NUM_REQ requesters.
// Optional statistics counters are enabled by defining LUT_ARB_STATS_EN.
module lut_read_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 8,
  parameter int VALID_ENTRIES = 15,
  parameter int CNT_W         = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rerr,
  output logic [ADDR_W-1:0]         lut_addr,
  input  logic [DATA_W-1:0]         lut_data
`ifdef LUT_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]          lookup_cnt,
  output logic [CNT_W-1:0]          err_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOOK} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   id_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [IDX_W-1:0]   winner;
  logic               found;
  logic               in_range;

  // Scan starting just after the last winner so the pointer rotates fairly.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(last) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  assign in_range = (int'(addr_q) < VALID_ENTRIES);
  assign lut_addr = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= LAST_RST;
      id_q   <= '0;
      addr_q <= '0;
      gnt    <= '0;
      rvalid <= '0;
      rdata  <= '0;
      rerr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rvalid <= '0;
          if (found) begin
            gnt    <= NUM_REQ'(1) << winner;
            addr_q <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            id_q   <= winner;
            last   <= winner;
            state  <= LOOK;
          end else begin
            gnt <= '0;
          end
        end
        LOOK: begin
          gnt    <= '0;
          rvalid <= NUM_REQ'(1) << id_q;
          rdata  <= in_range ? lut_data : '0;
          rerr   <= !in_range;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LUT_ARB_STATS_EN
  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_cnt <= '0;
      err_cnt    <= '0;
    end else if (state == LOOK) begin
      if (lookup_cnt != '1) lookup_cnt <= lookup_cnt + 1'b1;
      if (!in_range && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lut_read_arbiter.sv
// Directed testbench for lut_read_arbiter with a LUT holding 60+i at entries 0..14.
// Define LUT_ARB_STATS_EN to also exercise the statistics counters (built with CNT_W=2).
module tb_lut_read_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
`ifdef LUT_ARB_STATS_EN
  localparam int CNT_W   = 2;
`else
  localparam int CNT_W   = 16;
`endif

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      rerr;
  logic [ADDR_W-1:0]         lut_addr;
  logic [DATA_W-1:0]         lut_data;
`ifdef LUT_ARB_STATS_EN
  logic [CNT_W-1:0]          lookup_cnt;
  logic [CNT_W-1:0]          err_cnt;
`endif

  int checks = 0;
  int passed = 0;

  lut_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .VALID_ENTRIES(15), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rerr(rerr),
    .lut_addr(lut_addr), .lut_data(lut_data)
`ifdef LUT_ARB_STATS_EN
    , .lookup_cnt(lookup_cnt), .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unpopulated entries return junk so the DUT's zeroing is visible.
  always_comb lut_data = (lut_addr < 5'd15) ? 8'(60 + int'(lut_addr)) : 8'hEE;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    req_addr = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    req_addr = '0;
    #1;
    checks++;
    if ({gnt, rvalid, rdata, rerr, lut_addr} !== '0)
      $display("[TB] FAIL reset_outputs: got gnt=%b rvalid=%b rdata=%0d rerr=%b lut_addr=%0d, expected all zero",
               gnt, rvalid, rdata, rerr, lut_addr);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({gnt, rvalid} !== '0)
      $display("[TB] FAIL idle_after_reset: got gnt=%b rvalid=%b, expected 00 00", gnt, rvalid);
    else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    req = 2'b01;
    req_addr[0 +: ADDR_W] = 5'd3;
    tick();
    checks++;
    if (gnt !== 2'b01 || rvalid !== 2'b00)
      $display("[TB] FAIL basic_gnt: got gnt=%b rvalid=%b, expected 01 00", gnt, rvalid);
    else passed++;
    // Address changes after latching must not affect the result.
    req = 2'b00;
    req_addr[0 +: ADDR_W] = 5'd7;
    tick();
    checks++;
    if (gnt !== 2'b00 || rvalid !== 2'b01 || rdata !== 8'd63 || rerr !== 1'b0)
      $display("[TB] FAIL basic_resp: got gnt=%b rvalid=%b rdata=%0d rerr=%b, expected 00 01 63 0",
               gnt, rvalid, rdata, rerr);
    else passed++;
    tick();
    checks++;
    if (gnt !== 2'b00 || rvalid !== 2'b00 || rdata !== 8'd63)
      $display("[TB] FAIL basic_idle_hold: got gnt=%b rvalid=%b rdata=%0d, expected 00 00 63",
               gnt, rvalid, rdata);
    else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 2'b11;
    req_addr = {5'd14, 5'd0};
    tick();
    checks++;
    if (gnt !== 2'b01)
      $display("[TB] FAIL simul_gnt0: got %b, expected 01", gnt);
    else passed++;
    req = 2'b10;
    tick();
    checks++;
    if (rvalid !== 2'b01 || rdata !== 8'd60 || gnt !== 2'b00)
      $display("[TB] FAIL simul_resp0: got rvalid=%b rdata=%0d gnt=%b, expected 01 60 00", rvalid, rdata, gnt);
    else passed++;
    tick();
    checks++;
    if (gnt !== 2'b10 || rvalid !== 2'b00)
      $display("[TB] FAIL simul_gnt1: got gnt=%b rvalid=%b, expected 10 00", gnt, rvalid);
    else passed++;
    req = 2'b00;
    tick();
    checks++;
    if (rvalid !== 2'b10 || rdata !== 8'd74 || rerr !== 1'b0)
      $display("[TB] FAIL simul_resp1: got rvalid=%b rdata=%0d rerr=%b, expected 10 74 0", rvalid, rdata, rerr);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_id [4];
    logic [7:0] exp_data;
    exp_id = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req = 2'b11;
    req_addr = {5'd5, 5'd2};
    for (int n = 0; n < 4; n++) begin
      exp_data = (exp_id[n] == 2'b01) ? 8'd62 : 8'd65;
      tick();
      checks++;
      if (gnt !== exp_id[n] || rvalid !== 2'b00)
        $display("[TB] FAIL b2b_gnt%0d: got gnt=%b rvalid=%b, expected %b 00", n, gnt, rvalid, exp_id[n]);
      else passed++;
      if (n == 3) req = 2'b00;
      tick();
      checks++;
      if (gnt !== 2'b00 || rvalid !== exp_id[n] || rdata !== exp_data)
        $display("[TB] FAIL b2b_resp%0d: got gnt=%b rvalid=%b rdata=%0d, expected 00 %b %0d",
                 n, gnt, rvalid, rdata, exp_id[n], exp_data);
      else passed++;
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || rvalid !== 2'b00)
      $display("[TB] FAIL b2b_no_extra: got gnt=%b rvalid=%b, expected 00 00", gnt, rvalid);
    else passed++;
  endtask

  task automatic test_out_of_range();
    logic [4:0] addrs [3];
    logic [7:0] exp_d [3];
    logic       exp_e [3];
    addrs = '{5'd20, 5'd14, 5'd15};
    exp_d = '{8'd0, 8'd74, 8'd0};
    exp_e = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int n = 0; n < 3; n++) begin
      req = 2'b10;
      req_addr[ADDR_W +: ADDR_W] = addrs[n];
      tick();
      checks++;
      if (gnt !== 2'b10 || lut_addr !== addrs[n])
        $display("[TB] FAIL oor_gnt%0d: got gnt=%b lut_addr=%0d, expected 10 %0d", n, gnt, lut_addr, addrs[n]);
      else passed++;
      req = 2'b00;
      tick();
      checks++;
      if (rvalid !== 2'b10 || rdata !== exp_d[n] || rerr !== exp_e[n])
        $display("[TB] FAIL oor_resp%0d: got rvalid=%b rdata=%0d rerr=%b, expected 10 %0d %b",
                 n, rvalid, rdata, rerr, exp_d[n], exp_e[n]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    do_reset();
    req = 2'b01;
    req_addr = {5'd9, 5'd4};
    tick();
    req = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00 || rvalid !== 2'b00)
      $display("[TB] FAIL midreset_clear: got gnt=%b rvalid=%b, expected 00 00", gnt, rvalid);
    else passed++;
    #1;
    rst_n = 1'b1;
    stray = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (rvalid !== 2'b00) stray++;
    end
    checks++;
    if (stray !== 0)
      $display("[TB] FAIL midreset_no_resp: got %0d stray rvalid cycles, expected 0", stray);
    else passed++;
    req = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b01)
      $display("[TB] FAIL midreset_ptr: got gnt=%b, expected 01", gnt);
    else passed++;
    req = 2'b10;
    tick();
    checks++;
    if (rvalid !== 2'b01 || rdata !== 8'd64)
      $display("[TB] FAIL midreset_resp: got rvalid=%b rdata=%0d, expected 01 64", rvalid, rdata);
    else passed++;
    req = 2'b00;
    tick();
    tick();
    tick();
  endtask

`ifdef LUT_ARB_STATS_EN
  task automatic one_lookup(input logic [4:0] addr);
    req = 2'b01;
    req_addr[0 +: ADDR_W] = addr;
    tick();
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_stats();
    do_reset();
    checks++;
    if (lookup_cnt !== 2'd0 || err_cnt !== 2'd0)
      $display("[TB] FAIL stats_reset: got lookup=%0d err=%0d, expected 0 0", lookup_cnt, err_cnt);
    else passed++;
    one_lookup(5'd1);
    one_lookup(5'd31);
    one_lookup(5'd2);
    checks++;
    if (lookup_cnt !== 2'd3 || err_cnt !== 2'd1)
      $display("[TB] FAIL stats_count: got lookup=%0d err=%0d, expected 3 1", lookup_cnt, err_cnt);
    else passed++;
    one_lookup(5'd3);
    checks++;
    if (lookup_cnt !== 2'd3 || err_cnt !== 2'd1)
      $display("[TB] FAIL stats_saturate: got lookup=%0d err=%0d, expected 3 1", lookup_cnt, err_cnt);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
`ifdef LUT_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
